alu_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer that drives the ALU's 4-bit alu_control code and consumes its zero (condition-true) flag. It accepts one RV32I instruction at a time and decodes it to an ALU operation. It then steps through execute, memory and writeback phases, producing register-file, memory and PC strobes. It sits between instruction fetch and the datapath, and is the driver end of the alu_control/zero interface.

---
 rtl/riscv_ctrl_pkg.sv | 72 +++++++
 rtl/alu_op_decode.sv | 74 +++++++
 rtl/alu_ctrl_fsm.sv | 196 +++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle control sequencer: ALU operation
// codes, instruction opcodes, instruction classes and FSM states.
// Optional feature macro: RV32M_EN (adds the MULDIV state).
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_XOR  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001,
      ALU_BEQ  = 4'b1010,
      ALU_BNE  = 4'b1011,
      ALU_BLT  = 4'b1100,
      ALU_BGE  = 4'b1101,
      ALU_BLTU = 4'b1110,
      ALU_BGEU = 4'b1111
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      CLS_OP     = 3'd0,
      CLS_OP_IMM = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_MULDIV = 3'd5
   } instr_class_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
`ifdef RV32M_EN
      ,
      ST_MULDIV = 3'd6
`endif
   } ctrl_state_e;

   // Integer ALU mapping shared by OP and OP-IMM; alt selects sub/sra.
   function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3,
                                                  input logic       alt);
      alu_op_e op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decoder: instruction word -> ALU operation, class,
// illegal flag. Optional feature macro: RV32M_EN (accepts funct7=0000001 on OP).
module alu_op_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [31:0]  instr,
   output alu_op_e      alu_op,
   output instr_class_e cls,
   output logic         illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   // Register and immediate fields do not influence control decoding.
   logic unused_fields;
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   // Field extraction.
   always_comb begin
      opcode = instr[6:0];
      funct3 = instr[14:12];
      funct7 = instr[31:25];
   end

   // Opcode/funct decode into ALU operation and instruction class.
   always_comb begin
      alu_op  = ALU_ADD;
      cls     = CLS_OP;
      illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            cls = CLS_OP;
            if (funct7 == FUNCT7_MULDIV) begin
`ifdef RV32M_EN
               cls = CLS_MULDIV;
`else
               illegal = 1'b1;
`endif
            end else begin
               alu_op = alu_op_from_funct3(funct3, funct7[5]);
            end
         end
         OPC_OP_IMM: begin
            cls    = CLS_OP_IMM;
            // addi ignores bit 30 (it is immediate data); only srai uses it.
            alu_op = alu_op_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
         end
         OPC_LOAD: begin
            cls = CLS_LOAD;
         end
         OPC_STORE: begin
            cls = CLS_STORE;
         end
         OPC_BRANCH: begin
            cls = CLS_BRANCH;
            case (funct3)
               3'b000:  alu_op = ALU_BEQ;
               3'b001:  alu_op = ALU_BNE;
               3'b100:  alu_op = ALU_BLT;
               3'b101:  alu_op = ALU_BGE;
               3'b110:  alu_op = ALU_BLTU;
               3'b111:  alu_op = ALU_BGEU;
               default: illegal = 1'b1;
            endcase
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer driving the ALU alu_control/zero
// interface and register-file, memory and PC strobes.
// Optional feature macro: RV32M_EN (MULDIV state with md_start/md_op/md_done).
module alu_ctrl_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] instr,
   input  logic            instr_valid,
   output logic            instr_ack,
   input  logic            zero,
   output logic [3:0]      alu_control,
   output logic            alu_src_imm,
   output logic            mem_read,
   output logic            mem_write,
   input  logic            mem_ready,
   output logic            reg_write,
   output logic            pc_write,
   output logic            pc_src_branch,
   output logic            illegal,
   output logic            busy
`ifdef RV32M_EN
   ,
   output logic            md_start,
   output logic [2:0]      md_op,
   input  logic            md_done
`endif
);

   localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   ctrl_state_e     state_q,  state_d;
   logic [XLEN-1:0] instr_q,  instr_d;
   alu_op_e         alu_op_q, alu_op_d;
   instr_class_e    cls_q,    cls_d;
   logic [TMO_W-1:0] tmo_q,   tmo_d;

   alu_op_e      dec_op;
   instr_class_e dec_cls;
   logic         dec_illegal;
   logic         imm_class;

   alu_op_decode u_decode (
      .instr   (instr_q),
      .alu_op  (dec_op),
      .cls     (dec_cls),
      .illegal (dec_illegal)
   );

   // State and datapath-control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         instr_q  <= '0;
         alu_op_q <= ALU_ADD;
         cls_q    <= CLS_OP;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         alu_op_q <= alu_op_d;
         cls_q    <= cls_d;
         tmo_q    <= tmo_d;
      end
   end

   // Next-state logic; tmo counts wait cycles in MEM (and MULDIV).
   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      alu_op_d = alu_op_q;
      cls_d    = cls_q;
      tmo_d    = '0;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alu_op_d = dec_op;
            cls_d    = dec_cls;
            if (dec_illegal) begin
               state_d = ST_TRAP;
`ifdef RV32M_EN
            end else if (dec_cls == CLS_MULDIV) begin
               state_d = ST_MULDIV;
`endif
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (cls_q)
               CLS_BRANCH:          state_d = ST_IDLE;
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               default:             state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_TRAP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
`ifdef RV32M_EN
         ST_MULDIV: begin
            if (md_done) begin
               state_d = ST_WB;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_TRAP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
`endif
         ST_WB:   state_d = ST_IDLE;
         ST_TRAP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand-B immediate select by class.
   always_comb begin
      imm_class = (cls_q == CLS_OP_IMM) || (cls_q == CLS_LOAD) || (cls_q == CLS_STORE);
   end

   // Output decode; everything is forced low while rst is high.
   always_comb begin
      instr_ack     = 1'b0;
      alu_control   = ALU_ADD;
      alu_src_imm   = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      pc_write      = 1'b0;
      pc_src_branch = 1'b0;
      illegal       = 1'b0;
      busy          = 1'b0;
`ifdef RV32M_EN
      md_start      = 1'b0;
      md_op         = '0;
`endif
      if (!rst) begin
         busy = (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               instr_ack = instr_valid;
            end
            ST_EXEC: begin
               alu_control = alu_op_q;
               alu_src_imm = imm_class;
               if (cls_q == CLS_BRANCH) begin
                  pc_write      = 1'b1;
                  pc_src_branch = zero;
               end
            end
            ST_MEM: begin
               alu_control = alu_op_q;
               alu_src_imm = imm_class;
               mem_read    = (cls_q == CLS_LOAD);
               mem_write   = (cls_q == CLS_STORE);
               pc_write    = mem_ready && (cls_q == CLS_STORE);
            end
`ifdef RV32M_EN
            ST_MULDIV: begin
               alu_control = alu_op_q;
               md_start    = (tmo_q == '0);
               md_op       = instr_q[14:12];
            end
`endif
            ST_WB: begin
               alu_control = alu_op_q;
               alu_src_imm = imm_class;
               reg_write   = 1'b1;
               pc_write    = 1'b1;
            end
            ST_TRAP: begin
               illegal  = 1'b1;
               pc_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: strobe events are predicted into a
// scoreboard queue at issue time and matched when the DUT emits them.
module tb_alu_ctrl_fsm;

   localparam int MEMTO = 4;

   localparam int K_OP  = 0;
   localparam int K_BR  = 1;
   localparam int K_LD  = 2;
   localparam int K_ST  = 3;
   localparam int K_ILL = 4;
   localparam int K_TMO = 5;

   typedef struct {
      int         cyc;
      logic [3:0] flags;   // {reg_write, pc_write, pc_src_branch, illegal}
      logic [3:0] alu;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ack;
   logic        zero;
   logic [3:0]  alu_control;
   logic        alu_src_imm;
   logic        mem_read;
   logic        mem_write;
   logic        mem_ready;
   logic        reg_write;
   logic        pc_write;
   logic        pc_src_branch;
   logic        illegal;
   logic        busy;
`ifdef RV32M_EN
   logic        md_start;
   logic [2:0]  md_op;
   logic        md_done = 1'b0;
`endif

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   ev_t sb_q[$];

   logic [12:0] outs;
   assign outs = {instr_ack, alu_control, alu_src_imm, mem_read, mem_write,
                  reg_write, pc_write, pc_src_branch, illegal, busy};

   alu_ctrl_fsm #(.XLEN(32), .MEM_TIMEOUT(MEMTO)) dut (
      .clk           (clk),
      .rst           (rst),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ack     (instr_ack),
      .zero          (zero),
      .alu_control   (alu_control),
      .alu_src_imm   (alu_src_imm),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_ready     (mem_ready),
      .reg_write     (reg_write),
      .pc_write      (pc_write),
      .pc_src_branch (pc_src_branch),
      .illegal       (illegal),
      .busy          (busy)
`ifdef RV32M_EN
      ,
      .md_start      (md_start),
      .md_op         (md_op),
      .md_done       (md_done)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard: every strobe cycle must match the oldest predicted event.
   always @(negedge clk) begin : mon
      ev_t e;
      if (reg_write || pc_write || illegal) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_strobe", {28'd0, reg_write, pc_write, pc_src_branch, illegal}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_flags", {28'd0, reg_write, pc_write, pc_src_branch, illegal}, {28'd0, e.flags});
            chk("ev_alu", {28'd0, alu_control}, {28'd0, e.alu});
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic run(input string nm, input logic [31:0] ins, input logic [3:0] alu,
                      input logic imm, input int kind, input int mdelay, input logic zf);
      int  c;
      int  nmem;
      ev_t e;
      wait_idle();
      @(posedge clk); #2;
      instr = ins; instr_valid = 1'b1; zero = zf;
      c = cyc;
      case (kind)
         K_OP:    e = '{cyc: c + 3,          flags: 4'b1100,             alu: alu};
         K_BR:    e = '{cyc: c + 2,          flags: {2'b01, zf, 1'b0},   alu: alu};
         K_LD:    e = '{cyc: c + 4 + mdelay, flags: 4'b1100,             alu: alu};
         K_ST:    e = '{cyc: c + 3 + mdelay, flags: 4'b0100,             alu: alu};
         K_TMO:   e = '{cyc: c + 3 + MEMTO,  flags: 4'b0101,             alu: 4'b0000};
         default: e = '{cyc: c + 2,          flags: 4'b0101,             alu: 4'b0000};
      endcase
      sb_q.push_back(e);
      @(negedge clk);
      chk({nm, "_ack"}, {31'd0, instr_ack}, 32'd1);
      @(posedge clk); #2;
      instr_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_dec_alu"}, {28'd0, alu_control}, 32'd0);
      chk({nm, "_dec_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      if (kind != K_ILL) begin
         chk({nm, "_exec_alu"}, {28'd0, alu_control}, {28'd0, alu});
         chk({nm, "_exec_imm"}, {31'd0, alu_src_imm}, {31'd0, imm});
      end
      if (kind == K_LD || kind == K_ST || kind == K_TMO) begin
         nmem = (kind == K_TMO) ? MEMTO : mdelay + 1;
         for (int i = 0; i < nmem; i++) begin
            @(posedge clk); #2;
            mem_ready = (kind != K_TMO) && (i == mdelay);
            @(negedge clk);
            chk({nm, "_mem_rw"}, {30'd0, mem_read, mem_write},
                {30'd0, kind == K_LD, kind != K_LD});
            chk({nm, "_mem_alu"}, {28'd0, alu_control}, {28'd0, alu});
            chk({nm, "_mem_imm"}, {31'd0, alu_src_imm}, 32'd1);
         end
         @(posedge clk); #2;
         mem_ready = 1'b0;
      end
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int c;
      int acks;
      int ack2;
      rst = 1'b1; instr = '0; instr_valid = 1'b1; zero = 1'b0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs_in_rst", {19'd0, outs}, 32'd0);
      instr_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outs_after", {19'd0, outs}, 32'd0);

      run("sub",    32'h40208033, 4'b0001, 1'b0, K_OP,  0, 1'b0);
      run("and",    32'h0020F0B3, 4'b0100, 1'b0, K_OP,  0, 1'b0);
      run("sltu",   32'h0020B0B3, 4'b1001, 1'b0, K_OP,  0, 1'b0);
      run("sra",    32'h4020D0B3, 4'b0111, 1'b0, K_OP,  0, 1'b0);
      run("addi30", 32'h40100093, 4'b0000, 1'b1, K_OP,  0, 1'b0);
      run("srai",   32'h4010D093, 4'b0111, 1'b1, K_OP,  0, 1'b0);
      run("srli",   32'h0010D093, 4'b0110, 1'b1, K_OP,  0, 1'b0);
      run("bgeu",   32'h0020F063, 4'b1111, 1'b0, K_BR,  0, 1'b1);
      run("bne",    32'h00209063, 4'b1011, 1'b0, K_BR,  0, 1'b0);
      run("lw_d3",  32'h00002083, 4'b0000, 1'b1, K_LD,  3, 1'b0);
      run("lw_d0",  32'h00002083, 4'b0000, 1'b1, K_LD,  0, 1'b0);
      run("sw_d1",  32'h00102023, 4'b0000, 1'b1, K_ST,  1, 1'b0);
      run("illop",  32'h0000007F, 4'b0000, 1'b0, K_ILL, 0, 1'b0);
      run("br010",  32'h0020A063, 4'b0000, 1'b0, K_ILL, 0, 1'b0);
`ifndef RV32M_EN
      run("mul",    32'h022080B3, 4'b0000, 1'b0, K_ILL, 0, 1'b0);
`endif
      run("sw_tmo", 32'h00102023, 4'b0000, 1'b1, K_TMO, 0, 1'b0);

      // instr_valid held across two addi instructions: one ack each, no gap.
      wait_idle();
      @(posedge clk); #2;
      instr = 32'h00500093; instr_valid = 1'b1; zero = 1'b0;
      c = cyc; acks = 0; ack2 = -1;
      sb_q.push_back('{cyc: c + 3, flags: 4'b1100, alu: 4'b0000});
      sb_q.push_back('{cyc: c + 7, flags: 4'b1100, alu: 4'b0000});
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (instr_ack) begin
            acks++;
            if (acks == 2) ack2 = cyc;
         end
      end
      instr_valid = 1'b0;
      chk("b2b_ack_count", acks, 32'd2);
      chk("b2b_ack2_cycle", ack2, c + 4);
      wait_idle();

      // Reset while a store waits in MEM: everything drops, no strobes follow.
      @(posedge clk); #2;
      instr = 32'h00102023; instr_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #2;
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstmem_mem_write", {31'd0, mem_write}, 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmem_outs", {19'd0, outs}, 32'd0);
      repeat (3) @(negedge clk);
      chk("rstmem_idle_outs", {19'd0, outs}, 32'd0);

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
